// File: rtl/overlay_pkg.sv
// Shared geometry and write-FSM encoding for the 1-bit overlay bitmaps.
// The default image is 244x72 pixels, with its top-left corner at screen (209,181).
package overlay_pkg;

   localparam int IMG_W   = 244;
   localparam int IMG_H   = 72;
   localparam int ORG_ROW = 209;
   localparam int ORG_COL = 181;
   localparam int IMG_PIX = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_FILL,
      ST_DONE
   } wr_state_t;

endpackage

// File: rtl/bitmap_ram_1b.sv
// Simple dual-port 1-bit bitmap RAM: one write port and one registered read port.
// A read that is not enabled returns 0, so the output register doubles as the overlay pixel.
module bitmap_ram_1b
   import overlay_pkg::*;
#(
   parameter int DEPTH = IMG_PIX,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic          i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic          o_rdata
);

   logic r_mem [DEPTH];
   logic r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // The read sees the pre-write contents when it hits the address being written.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rdata <= 1'b0;
      end else begin
         r_rdata <= i_re ? r_mem[i_raddr] : 1'b0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/bitmap_loader.sv
// Unpacks a byte stream (MSB = leftmost pixel) into the overlay bitmap RAM.
// It also serves the VGA path with a two-stage windowed read.
module bitmap_loader #(
   parameter int IMG_W   = overlay_pkg::IMG_W,
   parameter int IMG_H   = overlay_pkg::IMG_H,
   parameter int ORG_ROW = overlay_pkg::ORG_ROW,
   parameter int ORG_COL = overlay_pkg::ORG_COL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        loaded,
   output logic        overflow,
   input  logic [12:0] row,
   input  logic [12:0] col,
   input  logic        show,
   output logic        pixel
);

   import overlay_pkg::*;

   localparam int          PIX_CNT = IMG_W * IMG_H;
   localparam int          AW      = $clog2(PIX_CNT);
   localparam logic [19:0] PIX_END = 20'(PIX_CNT);
   localparam logic [12:0] ROW_LO  = 13'(ORG_ROW);
   localparam logic [12:0] ROW_HI  = 13'(ORG_ROW + IMG_H);
   localparam logic [12:0] COL_LO  = 13'(ORG_COL);
   localparam logic [12:0] COL_HI  = 13'(ORG_COL + IMG_W);

   wr_state_t     r_state;
   logic [19:0]   r_waddr;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitCnt;
   logic          r_inReady;
   logic          r_loaded;
   logic          r_overflow;
   logic          r_inWin;
   logic [AW-1:0] r_raddr;

   logic          w_xfer;
   logic          w_inImage;
   logic          w_we;
   logic [19:0]   w_waddrNext;
   logic          w_rowIn;
   logic          w_colIn;
   logic          w_inWin;
   logic [19:0]   w_rowOff;
   logic [19:0]   w_colOff;
   logic [19:0]   w_raddr;
   logic          w_unusedRaddrHi;

   assign w_xfer      = in_valid && r_inReady;
   assign w_inImage   = (r_waddr < PIX_END);
   assign w_we        = (r_state == ST_UNPACK) && w_inImage;
   assign w_waddrNext = w_inImage ? (r_waddr + 20'd1) : r_waddr;

   // Write FSM. An SOF transfer restarts the load from any ready state.
   // Bits that fall past the end of the image are discarded without advancing the address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_waddr    <= 20'd0;
         r_shift    <= 8'd0;
         r_bitCnt   <= 3'd0;
         r_inReady  <= 1'b1;
         r_loaded   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FILL, ST_DONE: begin
               if (w_xfer) begin
                  if (in_sof) begin
                     r_waddr   <= 20'd0;
                     r_loaded  <= 1'b0;
                     r_shift   <= in_data;
                     r_bitCnt  <= 3'd0;
                     r_inReady <= 1'b0;
                     r_state   <= ST_UNPACK;
                  end else if (r_state == ST_FILL) begin
                     r_shift   <= in_data;
                     r_bitCnt  <= 3'd0;
                     r_inReady <= 1'b0;
                     r_state   <= ST_UNPACK;
                  end else begin
                     r_overflow <= 1'b1;
                  end
               end
            end
            ST_UNPACK: begin
               r_shift  <= {r_shift[6:0], 1'b0};
               r_waddr  <= w_waddrNext;
               r_bitCnt <= r_bitCnt + 3'd1;
               if (r_bitCnt == 3'd7) begin
                  r_inReady <= 1'b1;
                  if (w_waddrNext >= PIX_END) begin
                     r_loaded <= 1'b1;
                     r_state  <= ST_DONE;
                  end else begin
                     r_state  <= ST_FILL;
                  end
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_inReady <= 1'b1;
            end
         endcase
      end
   end

   assign w_rowIn  = (row >= ROW_LO) && (row < ROW_HI);
   assign w_colIn  = (col >= COL_LO) && (col < COL_HI);
   assign w_inWin  = show && r_loaded && w_rowIn && w_colIn;
   assign w_rowOff = {7'd0, row} - 20'(ORG_ROW);
   assign w_colOff = {7'd0, col} - 20'(ORG_COL);
   assign w_raddr  = (w_rowOff * 20'(IMG_W)) + w_colOff;

   // The window flag guarantees the address is below PIX_CNT, so the high bits never matter.
   assign w_unusedRaddrHi = ^w_raddr[19:AW];

   // Stage 1 of the read path; the RAM output register is stage 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inWin <= 1'b0;
         r_raddr <= '0;
      end else begin
         r_inWin <= w_inWin;
         r_raddr <= w_raddr[AW-1:0];
      end
   end

   bitmap_ram_1b #(
      .DEPTH (PIX_CNT),
      .AW    (AW)
   ) u_ram (
      .i_clk   (clk),
      .i_reset (reset),
      .i_we    (w_we),
      .i_waddr (r_waddr[AW-1:0]),
      .i_wdata (r_shift[7]),
      .i_re    (r_inWin),
      .i_raddr (r_raddr),
      .o_rdata (pixel)
   );

   assign in_ready = r_inReady;
   assign loaded   = r_loaded;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_bitmap_loader.sv
// Self-checking bench for bitmap_loader.
// Reads push their expected pixel into a queue, and a monitor compares each one two edges later.
module tb_bitmap_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        loaded;
   logic        overflow;
   logic [12:0] row = 13'd0;
   logic [12:0] col = 13'd0;
   logic        show = 1'b0;
   logic        pixel;

   int          errors = 0;
   int          checks = 0;
   logic        expQ[$];
   string       nameQ[$];
   logic        rdIssue = 1'b0;
   logic [1:0]  rdPipe = 2'b00;

   always #5 clk = ~clk;

   bitmap_loader dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_sof   (in_sof),
      .in_data  (in_data),
      .in_ready (in_ready),
      .loaded   (loaded),
      .overflow (overflow),
      .row      (row),
      .col      (col),
      .show     (show),
      .pixel    (pixel)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Queue one windowed read; its result is checked by the monitor two edges later.
   task automatic applyStimulus(input int r, input int c, input logic s, input logic exp);
      @(negedge clk);
      row     = 13'(r);
      col     = 13'(c);
      show    = s;
      rdIssue = 1'b1;
      expQ.push_back(exp);
      nameQ.push_back($sformatf("pixel(%0d,%0d,show=%0d)", r, c, s));
   endtask

   task automatic drainReads();
      @(negedge clk);
      rdIssue = 1'b0;
      show    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
   endtask

   task automatic sendPlain(input logic [7:0] data);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = data;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Streams nBytes with in_valid held high, starting at the first ready cycle.
   // cycles counts from the first accept cycle up to the last cycle before loaded is seen high.
   task automatic loadImage(input logic [7:0] firstByte, input logic [7:0] restByte, input int nBytes,
                            input bit waitLoaded, output int cycles, output int readyCnt);
      int sent;
      int guard;
      sent     = 0;
      cycles   = 0;
      readyCnt = 0;
      guard    = 0;
      @(negedge clk);
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL load start: in_ready=%0d required 1 within 20 cycles", in_ready);
      end
      in_valid = 1'b1;
      forever begin
         if (sent == nBytes && (loaded || !waitLoaded)) break;
         if (cycles >= 30000) begin
            checks++;
            errors++;
            $display("[TB] FAIL load timeout: loaded=%0d after %0d cycles, required 1", loaded, cycles);
            break;
         end
         cycles++;
         if (sent == nBytes) in_valid = 1'b0;
         if (in_ready && sent < nBytes) begin
            readyCnt++;
            in_sof  = (sent == 0);
            in_data = (sent == 0) ? firstByte : restByte;
            sent++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // Monitor: pops one expectation whenever a read reaches the pixel output.
   initial begin
      logic  e;
      string n;
      forever begin
         @(posedge clk);
         rdPipe = {rdPipe[0], rdIssue};
         @(negedge clk);
         if (rdPipe[1]) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard underflow: pixel=%0d with no expectation", pixel);
            end else begin
               e = expQ.pop_front();
               n = nameQ.pop_front();
               checkOutput(n, 32'(pixel), 32'(e));
            end
         end
      end
   end

   initial begin
      int cyc;
      int rdy;

      repeat (3) @(negedge clk);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset loaded", 32'(loaded), 32'd0);
      checkOutput("reset overflow", 32'(overflow), 32'd0);
      checkOutput("reset pixel", 32'(pixel), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(209, 181, 1'b1, 1'b0);
      applyStimulus(250, 300, 1'b1, 1'b0);
      drainReads();

      // A byte without SOF in IDLE is dropped and flags overflow.
      sendPlain(8'hFF);
      checkOutput("idle noSOF overflow", 32'(overflow), 32'd1);
      checkOutput("idle noSOF loaded", 32'(loaded), 32'd0);
      checkOutput("idle noSOF in_ready", 32'(in_ready), 32'd1);

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("overflow cleared by reset", 32'(overflow), 32'd0);

      // Checkerboard: 0xAA everywhere, so even pixel indices are 1 (the width is even).
      loadImage(8'hAA, 8'hAA, 2196, 1'b1, cyc, rdy);
      checkOutput("checker load cycles", 32'(cyc), 32'd19764);
      checkOutput("checker ready cycles", 32'(rdy), 32'd2196);
      checkOutput("checker loaded", 32'(loaded), 32'd1);
      checkOutput("checker overflow", 32'(overflow), 32'd0);
      for (int c = 181; c <= 188; c++) begin
         applyStimulus(209, c, 1'b1, ((c - 181) % 2 == 0) ? 1'b1 : 1'b0);
      end
      applyStimulus(210, 181, 1'b1, 1'b1);
      applyStimulus(210, 182, 1'b1, 1'b0);
      applyStimulus(280, 423, 1'b1, 1'b1);
      applyStimulus(280, 424, 1'b1, 1'b0);
      drainReads();

      // With show low, every in-window coordinate must read 0.
      for (int r = 209; r <= 280; r++) begin
         for (int c = 181; c <= 424; c++) begin
            applyStimulus(r, c, 1'b0, 1'b0);
         end
      end
      drainReads();

      // Abandon a load after 100 bytes, then restart with 0x00 followed by 0xFF bytes.
      loadImage(8'h55, 8'h55, 100, 1'b0, cyc, rdy);
      checkOutput("partial loaded", 32'(loaded), 32'd0);
      applyStimulus(209, 181, 1'b1, 1'b0);
      drainReads();
      loadImage(8'h00, 8'hFF, 2196, 1'b1, cyc, rdy);
      checkOutput("restart load cycles", 32'(cyc), 32'd19764);
      checkOutput("restart ready cycles", 32'(rdy), 32'd2196);
      checkOutput("restart loaded", 32'(loaded), 32'd1);
      checkOutput("restart overflow", 32'(overflow), 32'd0);
      applyStimulus(208, 181, 1'b1, 1'b0);
      applyStimulus(281, 181, 1'b1, 1'b0);
      applyStimulus(209, 180, 1'b1, 1'b0);
      applyStimulus(209, 425, 1'b1, 1'b0);
      applyStimulus(209, 181, 1'b1, 1'b0);
      applyStimulus(209, 188, 1'b1, 1'b0);
      applyStimulus(209, 189, 1'b1, 1'b1);
      applyStimulus(210, 181, 1'b1, 1'b1);
      applyStimulus(280, 424, 1'b1, 1'b1);
      applyStimulus(280, 424, 1'b0, 1'b0);
      drainReads();

      // An extra byte after the image is complete is dropped.
      sendPlain(8'h00);
      checkOutput("done extra overflow", 32'(overflow), 32'd1);
      checkOutput("done extra loaded", 32'(loaded), 32'd1);
      applyStimulus(209, 189, 1'b1, 1'b1);
      applyStimulus(280, 417, 1'b1, 1'b1);
      applyStimulus(280, 424, 1'b1, 1'b1);
      drainReads();

      // Reset while bits are being unpacked.
      loadImage(8'hFF, 8'hFF, 5, 1'b0, cyc, rdy);
      reset = 1'b1;
      #1;
      checkOutput("midload reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("midload reset loaded", 32'(loaded), 32'd0);
      checkOutput("midload reset overflow", 32'(overflow), 32'd0);
      checkOutput("midload reset pixel", 32'(pixel), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(209, 181, 1'b1, 1'b0);
      applyStimulus(209, 189, 1'b1, 1'b0);
      applyStimulus(280, 424, 1'b1, 1'b0);
      drainReads();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
